// File: rtl/cla_arb_pkg.sv
// Shared types and constants for the shared carry-lookahead adder arbiter.
package cla_arb_pkg;

  localparam int unsigned CLA_WIDTH = 32;
  localparam int unsigned MAX_REQ   = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StHold = 2'd2
  } state_t;

  typedef logic [CLA_WIDTH-1:0] operand_t;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder_32.sv
// 32-bit adder: 4-bit lookahead groups, group carries chained by group generate/propagate.
module carry_lookahead_adder_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    gg   = '0;
    gp   = '0;
    c[0] = cin_i;
    for (int k = 0; k < 8; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
    sum_o  = p ^ c[31:0];
    cout_o = c[32];
  end

endmodule

// File: rtl/cla_rr_pick.sv
// Round-robin picker: first valid requester after last_i, with wrap-around.
module cla_rr_pick
  import cla_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = id_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    last_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    idx_o,
  output logic              any_o
);

  logic [IdW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = IdW'((32'(last_i) + k) % NumReq);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cla_shared_arbiter.sv
// Round-robin sharing of one 32-bit CLA between NUM_REQ requesters; add/sub,
// registered operands, registered response held until consumed.
module cla_shared_arbiter
  import cla_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b_i,
  input  logic [NUM_REQ-1:0]              req_cin_i,
  input  logic [NUM_REQ-1:0]              req_sub_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [WIDTH-1:0]                rsp_sum_o,
  output logic                            rsp_cout_o,
  output logic [id_width(NUM_REQ)-1:0]    rsp_id_o
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  if (WIDTH != CLA_WIDTH) begin : g_width_chk
    $error("cla_shared_arbiter: WIDTH must be 32");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_num_req_chk
    $error("cla_shared_arbiter: NUM_REQ must be 2..8");
  end

  state_t         state_q, state_d;
  logic [IdW-1:0] last_q, last_d;
  operand_t       op_a_q, op_a_d, op_b_q, op_b_d;
  logic           op_cin_q, op_cin_d;
  logic [IdW-1:0] op_id_q, op_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  operand_t       rsp_sum_q, rsp_sum_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic [IdW-1:0] rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IdW-1:0]     gnt_idx;
  logic               any_valid;
  logic               window;
  logic               accept;
  operand_t           add_sum;
  logic               add_cout;

  cla_rr_pick #(
    .NumReq (NUM_REQ),
    .IdW    (IdW)
  ) u_pick (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (any_valid)
  );

  carry_lookahead_adder_32 u_cla (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .cin_i  (op_cin_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // rst_n gates the window so no requester sees ready while reset is held.
  assign window = rst_n && ((state_q == StIdle) || ((state_q == StHold) && rsp_ready_i));
  assign accept = window && any_valid;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    req_ready_o = window ? gnt : '0;

    if (accept) begin
      // Subtract as A + ~B + 1; the requester's carry-in is ignored.
      op_a_d   = req_a_i[gnt_idx];
      op_b_d   = req_sub_i[gnt_idx] ? ~req_b_i[gnt_idx] : req_b_i[gnt_idx];
      op_cin_d = req_sub_i[gnt_idx] | req_cin_i[gnt_idx];
      op_id_d  = gnt_idx;
      last_d   = gnt_idx;
    end

    case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? StExec : StIdle;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_q      <= IdW'(NUM_REQ - 1);
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_cla_shared_arbiter.sv
// Scoreboard bench for cla_shared_arbiter: round-robin/occupancy reference model,
// plain-arithmetic golden results, monitor comparing responses as they are consumed.
module tb_cla_shared_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][31:0]   req_a;
  logic [N-1:0][31:0]   req_b;
  logic [N-1:0]         req_cin;
  logic [N-1:0]         req_sub;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_sum;
  logic                 rsp_cout;
  logic [IDW-1:0]       rsp_id;

  cla_shared_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (32)
  ) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_cin_i   (req_cin),
    .req_sub_i   (req_sub),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_sum_o   (rsp_sum),
    .rsp_cout_o  (rsp_cout),
    .rsp_id_o    (rsp_id)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    int unsigned id;
    int unsigned acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
  } vec_t;

  exp_t         sb[$];
  int unsigned  log_id[$];
  int unsigned  log_cyc[$];
  int unsigned  n_chk = 0;
  int unsigned  n_pass = 0;

  // Reference model: one op in the adder stage, at most one held result.
  bit           m_exec;
  bit           m_held;
  int unsigned  m_last;
  int unsigned  mode;
  logic [N-1:0] refill_mask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name, input string why);
    n_chk++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
    if (sub) return {(a >= b), a - b};
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  function automatic int unsigned rr_next(input logic [N-1:0] v);
    int unsigned c;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1 << $urandom_range(0, 31);
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic set_req(input int unsigned i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
    req_a[i]     = a;
    req_b[i]     = b;
    req_cin[i]   = cin;
    req_sub[i]   = sub;
    req_valid[i] = 1'b1;
  endtask

  task automatic new_req(input int unsigned i);
    set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
  endtask

  // One clock: check req_ready against the model, book expected result, then drive.
  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs;
    logic [32:0]  r;
    int unsigned  g;
    bit           acc;
    @(negedge clk);
    exp_rdy = '0;
    acc     = 1'b0;
    g       = 0;
    if (!m_exec && (!m_held || rsp_ready) && (req_valid != '0)) begin
      g          = rr_next(req_valid);
      exp_rdy[g] = 1'b1;
      acc        = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    hs = req_valid & req_ready;
    if (acc) begin
      r = golden(req_a[g], req_b[g], req_cin[g], req_sub[g]);
      sb.push_back('{sum: r[31:0], cout: r[32], id: g, acc: cyc});
      m_last = g;
    end
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        log_id.push_back(i);
        log_cyc.push_back(cyc);
      end
    end
    m_held = m_exec || (m_held && !rsp_ready);
    m_exec = acc;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) req_valid[i] = 1'b0;
    if (mode == 1) begin
      for (int i = 0; i < N; i++) if (refill_mask[i] && !req_valid[i]) new_req(i);
    end else if (mode == 2) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && $urandom_range(0, 99) < 3) req_valid[i] = 1'b0;
        else if (!req_valid[i] && !hs[i] && $urandom_range(0, 99) < 40) new_req(i);
      end
      rsp_ready = ($urandom_range(0, 99) < 75);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_rsp", 64'({rsp_valid, rsp_sum, rsp_cout, rsp_id}), 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    sb.delete();
    m_exec = 1'b0;
    m_held = 1'b0;
    m_last = N - 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: stability while stalled, latency of each new result, value on consume.
  initial begin : monitor
    exp_t           e;
    bit             pv;
    bit             pr;
    logic [31:0]    ps;
    logic           pc;
    logic [IDW-1:0] pid;
    pv = 1'b0;
    pr = 1'b0;
    ps = '0;
    pc = 1'b0;
    pid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("rsp_hold", 64'({rsp_valid, rsp_sum, rsp_cout, rsp_id}), 64'({1'b1, ps, pc, pid}));
        end else if (rsp_valid) begin
          if (sb.size() == 0) fail("rsp_unexpected", "response with empty scoreboard");
          else chk("rsp_latency", 64'(cyc), 64'(sb[0].acc + 2));
        end
        if (rsp_valid && rsp_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp", 64'({rsp_sum, rsp_cout, rsp_id}), 64'({e.sum, e.cout, IDW'(e.id)}));
        end
        pv  = rsp_valid;
        pr  = rsp_ready;
        ps  = rsp_sum;
        pc  = rsp_cout;
        pid = rsp_id;
      end
    end
  end

  vec_t        dv[7];
  int unsigned ord_all[6];
  int unsigned ord_drop[4];

  initial begin
    dv[0] = '{a: 32'h0000_0005, b: 32'h0000_0003, cin: 1'b0, sub: 1'b0};
    dv[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0};
    dv[2] = '{a: 32'h0000_FFFF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0};
    dv[3] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0000, cin: 1'b1, sub: 1'b0};
    dv[4] = '{a: 32'h0000_0007, b: 32'h0000_0005, cin: 1'b0, sub: 1'b1};
    dv[5] = '{a: 32'h0000_0005, b: 32'h0000_0007, cin: 1'b0, sub: 1'b1};
    dv[6] = '{a: 32'h0000_0005, b: 32'h0000_0007, cin: 1'b1, sub: 1'b1};
    ord_all  = '{0, 1, 2, 3, 0, 1};
    ord_drop = '{0, 1, 3, 0};
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    req_sub = '0;
    rsp_ready = 1'b0;
    mode = 0;
    refill_mask = '0;
    m_exec = 1'b0;
    m_held = 1'b0;
    m_last = N - 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp", 64'({rsp_valid, rsp_sum, rsp_cout, rsp_id}), 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    rst_n = 1'b1;
    #1;
    rsp_ready = 1'b1;

    // Directed adds and subtracts, one at a time.
    for (int k = 0; k < 7; k++) begin
      set_req(k % N, dv[k].a, dv[k].b, dv[k].cin, dv[k].sub);
      repeat (3) step();
    end

    // Fairness with all requesters held valid.
    req_valid = '0;
    do_reset();
    rsp_ready = 1'b1;
    refill_mask = '1;
    for (int i = 0; i < N; i++) new_req(i);
    mode = 1;
    log_id.delete();
    log_cyc.delete();
    for (int k = 0; k < 40 && log_id.size() < 6; k++) step();
    if (log_id.size() < 6) begin
      fail("fair_timeout", "fewer than 6 accepts in 40 cycles");
    end else begin
      for (int k = 0; k < 6; k++) chk("fair_order", 64'(log_id[k]), 64'(ord_all[k]));
      for (int k = 1; k < 6; k++) chk("fair_spacing", 64'(log_cyc[k] - log_cyc[k-1]), 64'(2));
    end

    // Fairness with requester 2 idle.
    mode = 0;
    req_valid = '0;
    do_reset();
    refill_mask = 4'b1011;
    for (int i = 0; i < N; i++) if (refill_mask[i]) new_req(i);
    mode = 1;
    log_id.delete();
    log_cyc.delete();
    for (int k = 0; k < 40 && log_id.size() < 4; k++) step();
    if (log_id.size() < 4) fail("drop_timeout", "fewer than 4 accepts in 40 cycles");
    else for (int k = 0; k < 4; k++) chk("drop_order", 64'(log_id[k]), 64'(ord_drop[k]));

    // Backpressure in HOLD with everybody requesting.
    refill_mask = '1;
    for (int k = 0; k < 10 && !m_held; k++) step();
    if (!m_held) fail("hold_timeout", "no response held");
    rsp_ready = 1'b0;
    repeat (5) step();
    rsp_ready = 1'b1;
    repeat (6) step();

    // Reset while a response is held.
    rsp_ready = 1'b0;
    for (int k = 0; k < 10 && !m_held; k++) step();
    chk("held_before_reset", 64'(rsp_valid), 64'(1));
    do_reset();

    // Reset while the adder stage is busy; afterwards requester 0 wins over 3.
    mode = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    set_req(2, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    step();
    new_req(3);
    new_req(0);
    do_reset();
    log_id.delete();
    log_cyc.delete();
    step();
    if (log_id.size() == 0) fail("post_reset_grant", "no accept after reset");
    else chk("post_reset_grant", 64'(log_id[0]), 64'(0));
    repeat (6) step();

    // Randomized traffic with random backpressure and request drops.
    mode = 2;
    repeat (30000) step();
    mode = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) step();
    chk("drain", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
